scan_mux_n: RTL and testbench
=============================

Name: scan_mux_n

Overview:
Parametrised N-channel, WIDTH-bit multiplexer with a registered output. It is the successor to the fixed 4:1 single-bit mux.
- Manual mode: the output follows an external select.
- Scan mode: an internal round-robin scanner steps through the channels enabled in a mask, holding each one for DWELL cycles.
- It feeds downstream capture/display logic, which needs a valid strobe and the current channel index alongside the data.

Parameters:
WIDTH, 8, data width per channel
CHANNELS, 4, number of input channels (2..16)
SEL_W, 2, select/index width; must equal clog2(CHANNELS)
DWELL, 4, cycles spent on each channel in scan mode (>=1)

Ports:
clk      input   1               system clock, rising edge
rst      input   1               synchronous reset, active-high
din      input   WIDTH*CHANNELS  packed inputs; channel k = din[k*WIDTH +: WIDTH]
sel      input   SEL_W           channel select, manual mode
mode     input   1               0 = manual, 1 = scan
en       input   1               advance/update enable
ch_mask  input   CHANNELS        scan-mode channel enable, bit k = channel k
y        output  WIDTH           registered selected data
y_ch     output  SEL_W           channel index that y came from
y_valid  output  1               y/y_ch updated this cycle with a valid channel
wrap     output  1               one-cycle pulse: scan wrapped to lower/equal index

Behaviour:
- One clock, rst synchronous active-high, sampled on rising clk; rst dominates all other inputs.
- Reset values: y=0, y_ch=0, y_valid=0, wrap=0. Internal ptr=0, cnt=0, prev_mode=0.
- Latency: 1 cycle. Outputs reflect inputs sampled at the previous edge.
- en=0: y, y_ch, ptr, cnt hold; y_valid=0; wrap=0.
- Manual (mode=0, en=1):
  - y<=din[sel], y_ch<=sel, y_valid<=1.
  - sel>=CHANNELS: y<=0, y_ch<=sel, y_valid<=0.
  - ch_mask ignored; wrap=0.
  - ptr and cnt are not updated.
- Scan entry: prev_mode=0 and mode=1 with en=1.
  - ptr<=lowest set bit of ch_mask, cnt<=0.
  - Output that same cycle: y<=din[lowest], y_ch<=lowest, y_valid<=1.
- Scan (mode=1, en=1, not entry cycle):
  - Output y<=din[ptr], y_ch<=ptr, y_valid<=1.
  - cnt<DWELL-1: cnt<=cnt+1.
  - cnt==DWELL-1: cnt<=0 and ptr<=next set mask bit strictly above ptr. If there is none, ptr wraps to the lowest set bit, and wrap is pulsed in the cycle y_ch first shows the wrapped-to channel.
  - A single enabled channel re-selects itself on each dwell expiry; wrap pulses each time.
- Mask changes:
  - Current ptr's mask bit cleared: on the next enabled cycle ptr advances immediately to the next set bit (wrap rules apply), cnt<=0, and the masked channel is not output.
  - ch_mask=0 in scan: y_valid=0, y holds, ptr and cnt hold, wrap=0.
- Scan to manual: manual rules apply from the next edge. Re-entering scan always restarts at the lowest enabled channel.
- prev_mode<=mode every cycle, including en=0 cycles.
- DWELL=1: the channel advances every enabled cycle.

Test Plan:
Common config: WIDTH=8, CHANNELS=4, DWELL=2, din={8'h44,8'h33,8'h22,8'h11}.
1. Manual sweep: mode=0, en=1, sel=0,1,2,3 on successive edges -> y=11,22,33,44 one cycle later, y_valid=1, y_ch matches sel.
2. Full scan: mode 0->1, ch_mask=4'b1111 -> y=11,11,22,22,33,33,44,44,11,11; wrap=1 only in the cycle y first returns to 11.
3. Sparse mask: ch_mask=4'b0101 -> y=11,11,33,33,11,11, with y_ch=0,0,2,2,0,0. Then set ch_mask=0 -> y_valid=0 and y holds 11.
4. Mid-dwell masking: scanning on ch1 (first of two dwell cycles), clear bit1 -> next output is ch2 (33), cnt restarted; ch1 does not reappear.
5. Enable hold: en=0 for 3 cycles during ch2's first dwell cycle -> y=33 held, y_valid=0. On en=1 -> one more 33, then 44.
6. Reset mid-scan: assert rst for 1 cycle while showing ch3 -> next cycle y=0, y_ch=0, y_valid=0, wrap=0. With mode held 1, the next enabled cycle restarts at the lowest enabled channel.

Source files
------------

// File: rtl/scan_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : scan_mux_n
//  Description : N-channel, WIDTH-bit mux with registered output. Manual select
//                or round-robin scan over masked channels with per-channel dwell.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_mux_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH*CHANNELS-1:0] din,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       ch_mask,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          y_ch,
    output logic                      y_valid,
    output logic                      wrap
);

    localparam int                 c_span     = 2 ** SEL_W;
    localparam int                 c_cnt_w    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DWELL - 1);

    // Channel data, select validity and mask padded to the full index space so
    // any SEL_W-bit index is in range; padding slots read as zero/invalid.
    logic [WIDTH-1:0]  w_ch [c_span];
    logic [c_span-1:0] w_sel_ok;
    logic [c_span-1:0] w_mask;

    generate
        for (genvar k = 0; k < c_span; k++) begin : g_chan
            if (k < CHANNELS) begin : g_real
                assign w_ch[k]     = din[k*WIDTH +: WIDTH];
                assign w_sel_ok[k] = 1'b1;
                assign w_mask[k]   = ch_mask[k];
            end else begin : g_pad
                assign w_ch[k]     = '0;
                assign w_sel_ok[k] = 1'b0;
                assign w_mask[k]   = 1'b0;
            end
        end
    endgenerate

    logic [WIDTH-1:0]   r_y;
    logic [SEL_W-1:0]   r_y_ch;
    logic               r_y_valid;
    logic               r_wrap;
    logic [SEL_W-1:0]   r_ptr;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_prev_mode;

    logic [SEL_W-1:0]   w_low;
    logic               w_any;
    logic [SEL_W-1:0]   w_above;
    logic               w_has_above;
    logic [SEL_W-1:0]   w_step_ptr;
    logic               w_advance;

    // Descending scan: last hit is the lowest set bit / lowest set bit above ptr.
    always_comb begin
        w_low       = '0;
        w_any       = 1'b0;
        w_above     = '0;
        w_has_above = 1'b0;
        for (int k = c_span - 1; k >= 0; k--) begin
            if (w_mask[k]) begin
                w_low = SEL_W'(k);
                w_any = 1'b1;
                if (SEL_W'(k) > r_ptr) begin
                    w_above     = SEL_W'(k);
                    w_has_above = 1'b1;
                end
            end
        end
    end

    // A masked-out current channel is abandoned at once, same as dwell expiry.
    assign w_advance  = ~w_mask[r_ptr] | (r_cnt == c_cnt_last);
    assign w_step_ptr = w_has_above ? w_above : w_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= '0;
            r_y_ch      <= '0;
            r_y_valid   <= 1'b0;
            r_wrap      <= 1'b0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_prev_mode <= 1'b0;
        end else begin
            r_prev_mode <= mode;
            r_y_valid   <= 1'b0;
            r_wrap      <= 1'b0;
            if (en) begin
                if (!mode) begin
                    r_y       <= w_ch[sel];
                    r_y_ch    <= sel;
                    r_y_valid <= w_sel_ok[sel];
                end else if (w_any) begin
                    if (!r_prev_mode) begin
                        r_ptr     <= w_low;
                        r_cnt     <= '0;
                        r_y       <= w_ch[w_low];
                        r_y_ch    <= w_low;
                        r_y_valid <= 1'b1;
                    end else if (w_advance) begin
                        r_ptr     <= w_step_ptr;
                        r_cnt     <= '0;
                        r_y       <= w_ch[w_step_ptr];
                        r_y_ch    <= w_step_ptr;
                        r_y_valid <= 1'b1;
                        r_wrap    <= ~w_has_above;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_y       <= w_ch[r_ptr];
                        r_y_ch    <= r_ptr;
                        r_y_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign y       = r_y;
    assign y_ch    = r_y_ch;
    assign y_valid = r_y_valid;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_mux_n
//  Description : Directed scoreboard bench for scan_mux_n (W=8, N=4, DWELL=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_mux_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [1:0]  sel;
    logic        mode;
    logic        en;
    logic [3:0]  ch_mask;
    logic [7:0]  y;
    logic [1:0]  y_ch;
    logic        y_valid;
    logic        wrap;

    typedef struct {
        string      tag;
        logic [7:0] y;
        logic [1:0] ch;
        logic       v;
        logic       w;
    } exp_t;

    exp_t sbq[$];
    int   n_total = 0;
    int   n_pass  = 0;

    scan_mux_n #(
        .WIDTH    (8),
        .CHANNELS (4),
        .SEL_W    (2),
        .DWELL    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .sel     (sel),
        .mode    (mode),
        .en      (en),
        .ch_mask (ch_mask),
        .y       (y),
        .y_ch    (y_ch),
        .y_valid (y_valid),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic check_front();
        exp_t x;
        n_total++;
        if (sbq.size() == 0) begin
            $error("FAIL scoreboard_empty: got no expectation, want one queued");
        end else begin
            x = sbq.pop_front();
            assert ({y, y_ch, y_valid, wrap} === {x.y, x.ch, x.v, x.w}) n_pass++;
            else $error("FAIL %s: got y=%h ch=%0d v=%b w=%b, want y=%h ch=%0d v=%b w=%b",
                        x.tag, y, y_ch, y_valid, wrap, x.y, x.ch, x.v, x.w);
        end
    endtask

    // Drive one edge's inputs, queue what the DUT must show after that edge, check it.
    task automatic step(input logic r, input logic e, input logic m, input logic [1:0] s,
                        input logic [3:0] mk, input string tag, input logic [7:0] ey,
                        input logic [1:0] ech, input logic ev, input logic ew);
        exp_t x;
        rst = r; en = e; mode = m; sel = s; ch_mask = mk;
        x.tag = tag; x.y = ey; x.ch = ech; x.v = ev; x.w = ew;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        check_front();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0; ch_mask = 4'b0000;

        // Reset state
        step(1, 0, 0, 0, 4'b0000, "reset0", 8'h00, 0, 0, 0);
        step(1, 1, 1, 0, 4'b1111, "reset1", 8'h00, 0, 0, 0);

        // 1. Manual sweep, mask ignored
        step(0, 1, 0, 0, 4'b0000, "man_sel0", 8'h11, 0, 1, 0);
        step(0, 1, 0, 1, 4'b0000, "man_sel1", 8'h22, 1, 1, 0);
        step(0, 1, 0, 2, 4'b0000, "man_sel2", 8'h33, 2, 1, 0);
        step(0, 1, 0, 3, 4'b0000, "man_sel3", 8'h44, 3, 1, 0);
        step(0, 0, 0, 0, 4'b0000, "man_hold", 8'h44, 3, 0, 0);

        // 2. Full scan from entry
        step(0, 1, 1, 0, 4'b1111, "full_entry", 8'h11, 0, 1, 0);
        step(0, 1, 1, 0, 4'b1111, "full_c0b",   8'h11, 0, 1, 0);
        step(0, 1, 1, 0, 4'b1111, "full_c1a",   8'h22, 1, 1, 0);
        step(0, 1, 1, 0, 4'b1111, "full_c1b",   8'h22, 1, 1, 0);
        step(0, 1, 1, 0, 4'b1111, "full_c2a",   8'h33, 2, 1, 0);
        step(0, 1, 1, 0, 4'b1111, "full_c2b",   8'h33, 2, 1, 0);
        step(0, 1, 1, 0, 4'b1111, "full_c3a",   8'h44, 3, 1, 0);
        step(0, 1, 1, 0, 4'b1111, "full_c3b",   8'h44, 3, 1, 0);
        step(0, 1, 1, 0, 4'b1111, "full_wrap",  8'h11, 0, 1, 1);
        step(0, 1, 1, 0, 4'b1111, "full_c0d",   8'h11, 0, 1, 0);

        // 3. Sparse mask, then empty mask
        step(0, 1, 0, 0, 4'b0101, "sp_manual",  8'h11, 0, 1, 0);
        step(0, 1, 1, 0, 4'b0101, "sp_entry",   8'h11, 0, 1, 0);
        step(0, 1, 1, 0, 4'b0101, "sp_c0b",     8'h11, 0, 1, 0);
        step(0, 1, 1, 0, 4'b0101, "sp_c2a",     8'h33, 2, 1, 0);
        step(0, 1, 1, 0, 4'b0101, "sp_c2b",     8'h33, 2, 1, 0);
        step(0, 1, 1, 0, 4'b0101, "sp_wrap",    8'h11, 0, 1, 1);
        step(0, 1, 1, 0, 4'b0101, "sp_c0d",     8'h11, 0, 1, 0);
        step(0, 1, 1, 0, 4'b0000, "sp_empty0",  8'h11, 0, 0, 0);
        step(0, 1, 1, 0, 4'b0000, "sp_empty1",  8'h11, 0, 0, 0);

        // 4. Mid-dwell masking of ch1
        step(0, 1, 0, 1, 4'b1111, "mm_manual",  8'h22, 1, 1, 0);
        step(0, 1, 1, 0, 4'b1111, "mm_entry",   8'h11, 0, 1, 0);
        step(0, 1, 1, 0, 4'b1111, "mm_c0b",     8'h11, 0, 1, 0);
        step(0, 1, 1, 0, 4'b1111, "mm_c1a",     8'h22, 1, 1, 0);
        step(0, 1, 1, 0, 4'b1101, "mm_skip1",   8'h33, 2, 1, 0);

        // 5. Enable hold during ch2 first dwell cycle
        step(0, 0, 1, 0, 4'b1101, "hold0",      8'h33, 2, 0, 0);
        step(0, 0, 1, 0, 4'b1101, "hold1",      8'h33, 2, 0, 0);
        step(0, 0, 1, 0, 4'b1101, "hold2",      8'h33, 2, 0, 0);
        step(0, 1, 1, 0, 4'b1101, "hold_c2b",   8'h33, 2, 1, 0);
        step(0, 1, 1, 0, 4'b1101, "hold_c3a",   8'h44, 3, 1, 0);
        step(0, 1, 1, 0, 4'b1101, "mm_c3b",     8'h44, 3, 1, 0);
        step(0, 1, 1, 0, 4'b1101, "mm_wrap",    8'h11, 0, 1, 1);
        step(0, 1, 1, 0, 4'b1101, "mm_c0b2",    8'h11, 0, 1, 0);
        step(0, 1, 1, 0, 4'b1101, "mm_no_ch1",  8'h33, 2, 1, 0);
        step(0, 1, 1, 0, 4'b1101, "mm_c2b2",    8'h33, 2, 1, 0);
        step(0, 1, 1, 0, 4'b1101, "mm_c3a2",    8'h44, 3, 1, 0);

        // 6. Reset while showing ch3, then restart at lowest enabled
        step(1, 1, 1, 0, 4'b1101, "rst_mid",    8'h00, 0, 0, 0);
        step(0, 1, 1, 0, 4'b1101, "rst_entry",  8'h11, 0, 1, 0);
        step(0, 1, 1, 0, 4'b1101, "rst_c0b",    8'h11, 0, 1, 0);
        step(0, 1, 1, 0, 4'b1101, "rst_c2a",    8'h33, 2, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
